// File: rtl/fabric_rr_arbiter_pkg.sv
// Shared fabric constants and types used by the slave-port arbiter blocks.
package fabric_rr_arbiter_pkg;

  localparam int FABRIC_NREQ      = 4;
  localparam int FABRIC_IDW       = 2;
  localparam int FABRIC_TMO_LIMIT = 255;
  localparam int FABRIC_TMO_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fabric_rr_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after last_id+1,
// wrapping around.
module fabric_rr_pick
  import fabric_rr_arbiter_pkg::*;
#(
  parameter int NREQ = FABRIC_NREQ,
  parameter int IDW  = FABRIC_IDW
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_id,
  output logic            valid,
  output logic [IDW-1:0]  winner
);

  int              cand;
  logic [IDW-1:0]  cand_idx;

  // Walk from farthest to nearest offset so the nearest set bit lands last.
  always_comb begin
    valid    = |req;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand     = (int'(last_id) + i) % NREQ;
      cand_idx = IDW'(cand);
      if (req[cand_idx]) winner = cand_idx;
    end
  end

endmodule

// File: rtl/fabric_rr_arbiter.sv
// Round-robin arbiter granting one slave port to NREQ masters, with done-based
// release and an optional ownership timeout.
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | no owner; any request is arbitrated and granted next edge
// ST_BUSY | one owner holds the port until its done strobe or timeout
module fabric_rr_arbiter
  import fabric_rr_arbiter_pkg::*;
#(
  parameter int NREQ      = FABRIC_NREQ,
  parameter int IDW       = FABRIC_IDW,
  parameter int TMO_LIMIT = FABRIC_TMO_LIMIT,
  parameter int TMO_WIDTH = FABRIC_TMO_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_done,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_gnt_id,
  output logic            o_busy,
  output logic            o_tmo,
  output logic [IDW-1:0]  o_tmo_id
);

  localparam bit TMO_EN = (TMO_LIMIT != 0);
  // Counter value during the last BUSY cycle allowed before forced release.
  localparam logic [TMO_WIDTH-1:0] TMO_LAST =
    TMO_WIDTH'((TMO_LIMIT == 0) ? 0 : TMO_LIMIT - 1);

  arb_state_t           state_q, state_d;
  logic [NREQ-1:0]      gnt_d;
  logic [IDW-1:0]       gnt_id_d;
  logic                 busy_d;
  logic                 tmo_d;
  logic [IDW-1:0]       tmo_id_d;
  logic [TMO_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]       last_q, last_d;
  logic                 pick_valid;
  logic [IDW-1:0]       pick_id;
  logic                 tmo_hit;

  fabric_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (i_req),
    .last_id (last_q),
    .valid   (pick_valid),
    .winner  (pick_id)
  );

  assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    gnt_d    = o_gnt;
    gnt_id_d = o_gnt_id;
    busy_d   = o_busy;
    tmo_d    = 1'b0;
    tmo_id_d = o_tmo_id;
    cnt_d    = cnt_q;
    last_d   = last_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_valid) begin
          state_d        = ST_BUSY;
          gnt_d[pick_id] = 1'b1;
          gnt_id_d       = pick_id;
          busy_d         = 1'b1;
          cnt_d          = '0;
          last_d         = pick_id;
        end
      end
      ST_BUSY: begin
        // Owner's done beats a coincident timeout.
        if (i_done[o_gnt_id]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (tmo_hit) begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          busy_d   = 1'b0;
          tmo_d    = 1'b1;
          tmo_id_d = o_gnt_id;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      o_gnt    <= '0;
      o_gnt_id <= '0;
      o_busy   <= 1'b0;
      o_tmo    <= 1'b0;
      o_tmo_id <= '0;
      cnt_q    <= '0;
      last_q   <= IDW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      o_gnt    <= gnt_d;
      o_gnt_id <= gnt_id_d;
      o_busy   <= busy_d;
      o_tmo    <= tmo_d;
      o_tmo_id <= tmo_id_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_fabric_rr_arbiter.sv
// Scoreboard bench for fabric_rr_arbiter: a behavioural model predicts each
// cycle's outputs; a monitor compares them one cycle-edge later.
module tb_fabric_rr_arbiter;

  localparam int NREQ      = 4;
  localparam int IDW       = 2;
  localparam int TMO_LIMIT = 4;
  localparam int TMO_WIDTH = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] i_req = '0;
  logic [NREQ-1:0] i_done = '0;
  logic [NREQ-1:0] o_gnt;
  logic [IDW-1:0]  o_gnt_id;
  logic            o_busy;
  logic            o_tmo;
  logic [IDW-1:0]  o_tmo_id;

  fabric_rr_arbiter #(
    .NREQ      (NREQ),
    .IDW       (IDW),
    .TMO_LIMIT (TMO_LIMIT),
    .TMO_WIDTH (TMO_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_done   (i_done),
    .o_gnt    (o_gnt),
    .o_gnt_id (o_gnt_id),
    .o_busy   (o_busy),
    .o_tmo    (o_tmo),
    .o_tmo_id (o_tmo_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gnt;
    int busy;
    int gnt_id;
    int tmo;
    int tmo_id;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  bit   done_run = 0;

  // Model state: owner index (-1 when free), ring pointer, BUSY cycles served.
  int m_owner  = -1;
  int m_last   = NREQ - 1;
  int m_age    = 0;
  int m_tmo    = 0;
  int m_tmo_id = 0;

  function automatic void model_step(input logic r, input logic [NREQ-1:0] rq,
                                     input logic [NREQ-1:0] dn);
    if (r) begin
      m_owner = -1; m_last = NREQ - 1; m_age = 0; m_tmo = 0; m_tmo_id = 0;
      return;
    end
    m_tmo = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (rq[c]) begin
          m_owner = c; m_last = c; m_age = 0;
          break;
        end
      end
    end else if (dn[m_owner]) begin
      m_owner = -1;
    end else begin
      m_age++;
      if (m_age >= TMO_LIMIT) begin
        m_tmo = 1; m_tmo_id = m_owner; m_owner = -1;
      end
    end
  endfunction

  task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] dn);
    exp_t e;
    @(negedge clk);
    rst = r; i_req = rq; i_done = dn;
    model_step(r, rq, dn);
    e.gnt    = (m_owner >= 0) ? (1 << m_owner) : 0;
    e.busy   = (m_owner >= 0) ? 1 : 0;
    e.gnt_id = (m_owner >= 0) ? m_owner : 0;
    e.tmo    = m_tmo;
    e.tmo_id = m_tmo_id;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are registered, so each pushed expectation is valid just
  // after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt", int'(o_gnt), e.gnt);
        chk("busy", int'(o_busy), e.busy);
        chk("tmo", int'(o_tmo), e.tmo);
        chk("tmo_id", int'(o_tmo_id), e.tmo_id);
        if (e.busy != 0) chk("gnt_id", int'(o_gnt_id), e.gnt_id);
        chk("gnt_onehot0", int'($onehot0(o_gnt)), 1);
      end
    end
  end

  // Owner's done bit when it has served 'age' BUSY cycles, else nothing.
  function automatic logic [NREQ-1:0] owner_done_at(input int age);
    logic [NREQ-1:0] d;
    d = '0;
    if (m_owner >= 0 && m_age == age) d[m_owner] = 1'b1;
    return d;
  endfunction

  initial begin
    logic [NREQ-1:0] rq, dn;
    step(1, '0, '0);
    step(1, '0, '0);

    // Single request, done in third BUSY cycle.
    step(0, 4'b0001, '0);
    step(0, 4'b0000, '0);
    step(0, 4'b0000, '0);
    step(0, 4'b0000, 4'b0001);
    step(0, 4'b0000, '0);

    // All requesting, owner done every third BUSY cycle: order 0,1,2,3,0.
    step(1, '0, '0);
    for (int i = 0; i < 21; i++) step(0, 4'b1111, owner_done_at(2));
    step(0, '0, owner_done_at(m_age));
    step(0, '0, owner_done_at(m_age));

    // Wrap: last=1, 0011 -> 0; then 1001 -> 3.
    step(1, '0, '0);
    step(0, 4'b0010, '0);
    step(0, 4'b0000, 4'b0010);
    step(0, 4'b0011, '0);
    step(0, 4'b0000, 4'b0001);
    step(0, 4'b1001, '0);
    step(0, 4'b0000, 4'b1000);
    step(0, 4'b0000, '0);

    // Owner 2 never done: timeout after TMO_LIMIT BUSY cycles, then 3 granted.
    step(1, '0, '0);
    step(0, 4'b0100, '0);
    for (int i = 0; i < 7; i++) step(0, 4'b1100, 4'b0011);
    step(0, 4'b0000, 4'b1000);
    step(0, 4'b0000, '0);

    // Owner 1: foreign done ignored; own done coincident with timeout wins.
    step(1, '0, '0);
    step(0, 4'b0010, '0);
    for (int i = 0; i < 3; i++) step(0, 4'b0010, 4'b0100);
    step(0, 4'b0000, 4'b0010);
    step(0, 4'b0000, '0);
    step(0, 4'b0000, '0);

    // Done while idle is ignored.
    step(0, 4'b0000, 4'b1111);

    // Reset mid-BUSY, then lowest requester wins.
    step(0, 4'b0100, '0);
    step(0, 4'b0100, '0);
    step(1, 4'b0100, '0);
    step(0, 4'b1010, '0);
    step(0, 4'b0000, 4'b0010);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rq = NREQ'($urandom);
      dn = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
      if ($urandom_range(0, 3) == 0) dn = dn | owner_done_at(m_age);
      step($urandom_range(0, 199) == 0, rq, dn);
    end

    step(0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fabric_rr_arbiter.md
FABRIC_RR_ARBITER -- requirements
Module: fabric_rr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesting masters sharing one slave port, range 2..8.
REQ-002 Parameter IDW, default 2: width of requester index, equals clog2(NREQ).
REQ-003 Parameter TMO_LIMIT, default 255: BUSY cycles without done before forced release; 0 disables timeout.
REQ-004 Parameter TMO_WIDTH, default 8: timeout counter width; TMO_LIMIT SHALL fit.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 i_req  input  NREQ  per-master transaction request, level.
REQ-008 i_done  input  NREQ  per-master transaction-complete strobe, one cycle.
REQ-009 o_gnt  output  NREQ  one-hot grant, registered; drives slave-port switch select.
REQ-010 o_gnt_id  output  IDW  index of current owner; valid only while o_busy=1.
REQ-011 o_busy  output  1  port owned (BUSY state).
REQ-012 o_tmo  output  1  one-cycle pulse: owner forcibly released on timeout.
REQ-013 o_tmo_id  output  IDW  index of released owner; held until next timeout.

Function
REQ-014 FSM SHALL have two states: IDLE (no owner) and BUSY (one owner).
REQ-015 IDLE with i_req!=0 SHALL select winner and enter BUSY next edge; o_gnt/o_busy asserted in the cycle after request is sampled (latency 1).
REQ-016 Winner SHALL be first set bit of i_req searching from (last_id+1) mod NREQ upward with wrap-around (round-robin).
REQ-017 last_id SHALL update to winner index on every grant.
REQ-018 BUSY SHALL hold o_gnt/o_gnt_id stable regardless of i_req changes, including owner dropping i_req.
REQ-019 BUSY SHALL leave to IDLE on the edge where i_done[o_gnt_id]=1; o_gnt=0 for at least one cycle before next grant (one-cycle bubble).
REQ-020 i_done bits of non-owners SHALL be ignored in all states; any i_done in IDLE SHALL be ignored.
REQ-021 Timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle, saturating.
REQ-022 When counter reaches TMO_LIMIT (TMO_LIMIT!=0) without owner done, FSM SHALL go IDLE, pulse o_tmo for one cycle, load o_tmo_id with owner index.
REQ-023 Owner done in the same cycle as timeout SHALL win: normal release, no o_tmo.
REQ-024 Timed-out requester SHALL remain eligible; round-robin pointer still advances past it.
REQ-025 o_gnt SHALL be zero or one-hot in every cycle.

Reset
REQ-026 On rst=1 at an edge: state IDLE, o_gnt=0, o_busy=0, o_gnt_id=0, o_tmo=0, o_tmo_id=0, counter=0, last_id=NREQ-1 (requester 0 wins first).
REQ-027 rst asserted during BUSY SHALL drop grant at that edge without o_tmo pulse; rst SHALL take priority over all other events.

Structure
REQ-028 Default NREQ/IDW/TMO_LIMIT values SHALL be defined as constants in the shared fabric header included by fabric blocks.
REQ-029 Round-robin selection SHALL be a combinational sub-module fabric_rr_pick (inputs: request vector, last_id; outputs: valid, winner index).
REQ-030 All outputs SHALL be driven directly from registers.

Verification
REQ-031 Reset, then i_req=4'b0001 cycle 0 -> o_gnt=0001, o_gnt_id=0, o_busy=1 at cycle 1; i_done=0001 at cycle 3 -> o_gnt=0 at cycle 4.
REQ-032 i_req=4'b1111 held, owner done every 3rd BUSY cycle -> grant order 0,1,2,3,0 with one idle cycle between each.
REQ-033 last_id=1, i_req=4'b0011 -> grant 0 (wrap); then i_req=4'b1001 -> grant 3.
REQ-034 TMO_LIMIT=4, owner 2 never done -> release after 4 BUSY cycles, o_tmo one-cycle pulse, o_tmo_id=2, next requester granted.
REQ-035 Owner 1 busy, i_done=4'b0100 -> grant holds; i_done=0010 coincident with timeout edge -> release, o_tmo=0.
REQ-036 rst=1 mid-BUSY -> all outputs at reset values next cycle; first grant afterward goes to lowest requesting index.
